// File: rtl/smolproc_io_pkg.sv
// Shared definitions for the smolproc memory-mapped I/O blocks.
// Holds the UART transmitter state encoding and I/O map constants.
package smolproc_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int         UART_FRAME_BITS = 10;
    localparam logic [7:0] IO_UART_ADDR    = 8'hFF;

endpackage

// File: rtl/io_fifo.sv
// Small circular FIFO for the I/O path; the pointers carry one extra MSB
// so full and empty can be told apart. The caller gates push and pop.
module io_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             sig_clk,
    input  logic             sig_rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop};
    end

    always_ff @(posedge sig_clk or negedge sig_rst_n) begin
        if (!sig_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: resetting the pointers discards the contents.
    always_ff @(posedge sig_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

endmodule

// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter fed by the memory-mapped output port. Bytes are
// queued in a small FIFO and sent back-to-back with a registered TX line.
module uart_tx_module
    import smolproc_io_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 16,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       sig_clk,
    input  logic       sig_rst_n,
    input  logic [7:0] IO_data,
    input  logic       IO_sig_strobe,
    input  logic       IO_sig_ovf_clr,
    output logic       UART_tx,
    output logic       IO_sig_full,
    output logic       IO_sig_busy,
    output logic       IO_sig_ovf
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       pop;
    logic       push;
    logic       baud_end;

    // A full FIFO still takes a byte when the transmitter pops in the same cycle.
    assign push     = IO_sig_strobe && (!fifo_full || pop);
    assign baud_end = (baud_q == BAUD_LAST);

    io_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .sig_clk   (sig_clk),
        .sig_rst_n (sig_rst_n),
        .push      (push),
        .pop       (pop),
        .wr_data   (IO_data),
        .rd_data   (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // TX is registered from the next state so the line never glitches.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        if (IO_sig_strobe && !push) begin
            ovf_d = 1'b1;
        end else if (IO_sig_ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge sig_clk or negedge sig_rst_n) begin
        if (!sig_rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign UART_tx     = tx_q;
    assign IO_sig_full = fifo_full;
    assign IO_sig_busy = (state_q != IDLE) || !fifo_empty;
    assign IO_sig_ovf  = ovf_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed self-checking bench for uart_tx_module; a background monitor
// decodes every frame on UART_tx and records when each start bit began.
module tb_uart_tx_module;

    localparam int CPB        = 16;
    localparam int FRAME_CLKS = smolproc_io_pkg::UART_FRAME_BITS * CPB;

    logic       sig_clk        = 1'b0;
    logic       sig_rst_n      = 1'b0;
    logic [7:0] IO_data        = 8'h00;
    logic       IO_sig_strobe  = 1'b0;
    logic       IO_sig_ovf_clr = 1'b0;
    logic       UART_tx;
    logic       IO_sig_full;
    logic       IO_sig_busy;
    logic       IO_sig_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [9:0] frame_q [$];
    int         start_q [$];
    logic [9:0] mon_frame;

    uart_tx_module #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .sig_clk        (sig_clk),
        .sig_rst_n      (sig_rst_n),
        .IO_data        (IO_data),
        .IO_sig_strobe  (IO_sig_strobe),
        .IO_sig_ovf_clr (IO_sig_ovf_clr),
        .UART_tx        (UART_tx),
        .IO_sig_full    (IO_sig_full),
        .IO_sig_busy    (IO_sig_busy),
        .IO_sig_ovf     (IO_sig_ovf)
    );

    always #5 sig_clk = ~sig_clk;

    always @(posedge sig_clk) cyc <= cyc + 1;

    // Frame monitor: samples the middle of each of the ten bit periods.
    initial begin
        forever begin
            @(negedge sig_clk);
            if (sig_rst_n === 1'b1 && UART_tx === 1'b0) begin
                start_q.push_back(cyc);
                repeat (CPB / 2 - 1) @(negedge sig_clk);
                for (int i = 0; i < 10; i++) begin
                    mon_frame[i] = UART_tx;
                    if (i < 9) repeat (CPB) @(negedge sig_clk);
                end
                frame_q.push_back(mon_frame);
            end
        end
    end

    task automatic test_reset();
        sig_rst_n = 1'b0;
        repeat (3) @(negedge sig_clk);
        n_checks++;
        if ({UART_tx, IO_sig_busy, IO_sig_full, IO_sig_ovf} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %b expected 1000",
                     {UART_tx, IO_sig_busy, IO_sig_full, IO_sig_ovf});
        end
        sig_rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge sig_clk);
            n_checks++;
            if ({UART_tx, IO_sig_busy, IO_sig_full, IO_sig_ovf} !== 4'b1000) begin
                n_fail++;
                $display("[TB] FAIL idle_cycle_%0d: got %b expected 1000", i,
                         {UART_tx, IO_sig_busy, IO_sig_full, IO_sig_ovf});
            end
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] got;
        frame_q.delete();
        start_q.delete();
        @(negedge sig_clk);
        IO_data       = 8'hA5;
        IO_sig_strobe = 1'b1;
        @(negedge sig_clk);
        IO_sig_strobe = 1'b0;
        n_checks++;
        if ({UART_tx, IO_sig_busy} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL single_after_strobe tx,busy: got %b expected 11", {UART_tx, IO_sig_busy});
        end
        @(negedge sig_clk);
        n_checks++;
        if (UART_tx !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_start_latency tx: got %b expected 0", UART_tx);
        end
        repeat (FRAME_CLKS - 1) @(negedge sig_clk);
        n_checks++;
        if (IO_sig_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_busy_last_cycle: got %b expected 1", IO_sig_busy);
        end
        @(negedge sig_clk);
        n_checks++;
        if ({UART_tx, IO_sig_busy} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL single_busy_release tx,busy: got %b expected 10", {UART_tx, IO_sig_busy});
        end
        n_checks++;
        if (frame_q.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL single_frame_count: got %0d expected 1", frame_q.size());
        end else begin
            got = frame_q.pop_front();
            n_checks++;
            if (got !== 10'b1101001010) begin
                n_fail++;
                $display("[TB] FAIL single_frame_bits: got %b expected 1101001010", got);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] expected [3];
        logic [9:0] got;
        int         k;
        expected[0] = 10'b1_00000001_0;
        expected[1] = 10'b1_00000010_0;
        expected[2] = 10'b1_00000011_0;
        frame_q.delete();
        start_q.delete();
        @(negedge sig_clk);
        IO_sig_strobe = 1'b1;
        IO_data       = 8'h01;
        @(negedge sig_clk);
        IO_data       = 8'h02;
        @(negedge sig_clk);
        IO_data       = 8'h03;
        @(negedge sig_clk);
        IO_sig_strobe = 1'b0;
        k = 0;
        while (frame_q.size() < 3 && k < 700) begin
            @(negedge sig_clk);
            k++;
        end
        n_checks++;
        if (frame_q.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL b2b_frame_count: got %0d expected 3", frame_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                got = frame_q.pop_front();
                n_checks++;
                if (got !== expected[i]) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_frame_%0d: got %b expected %b", i, got, expected[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (start_q[i] - start_q[i-1] != FRAME_CLKS) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_spacing_%0d: got %0d expected %0d", i,
                             start_q[i] - start_q[i-1], FRAME_CLKS);
                end
            end
        end
        repeat (20) @(negedge sig_clk);
        n_checks++;
        if ({IO_sig_busy, IO_sig_ovf} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL b2b_end busy,ovf: got %b expected 00", {IO_sig_busy, IO_sig_ovf});
        end
    endtask

    task automatic test_overflow();
        logic [9:0] got;
        int         k;
        frame_q.delete();
        start_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge sig_clk);
            if (i == 5) begin
                n_checks++;
                if ({IO_sig_full, IO_sig_ovf} !== 2'b10) begin
                    n_fail++;
                    $display("[TB] FAIL ovf_fill full,ovf: got %b expected 10", {IO_sig_full, IO_sig_ovf});
                end
            end
            IO_sig_strobe = 1'b1;
            IO_data       = 8'h10 + 8'(i);
        end
        // Another drop in the same cycle as a clear must leave the flag set.
        @(negedge sig_clk);
        n_checks++;
        if (IO_sig_ovf !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ovf_set: got %b expected 1", IO_sig_ovf);
        end
        IO_data        = 8'h16;
        IO_sig_ovf_clr = 1'b1;
        @(negedge sig_clk);
        IO_sig_strobe  = 1'b0;
        IO_sig_ovf_clr = 1'b0;
        n_checks++;
        if ({IO_sig_full, IO_sig_ovf} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL ovf_set_wins full,ovf: got %b expected 11", {IO_sig_full, IO_sig_ovf});
        end
        k = 0;
        while (IO_sig_busy !== 1'b0 && k < 1000) begin
            @(negedge sig_clk);
            k++;
        end
        n_checks++;
        if (frame_q.size() != 5) begin
            n_fail++;
            $display("[TB] FAIL ovf_frame_count: got %0d expected 5", frame_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                got = frame_q.pop_front();
                n_checks++;
                if (got !== {1'b1, 8'h10 + 8'(i), 1'b0}) begin
                    n_fail++;
                    $display("[TB] FAIL ovf_frame_%0d: got %b expected %b", i, got,
                             {1'b1, 8'h10 + 8'(i), 1'b0});
                end
            end
        end
        n_checks++;
        if (IO_sig_ovf !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ovf_sticky: got %b expected 1", IO_sig_ovf);
        end
        @(negedge sig_clk);
        IO_sig_ovf_clr = 1'b1;
        @(negedge sig_clk);
        IO_sig_ovf_clr = 1'b0;
        n_checks++;
        if (IO_sig_ovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ovf_clear: got %b expected 0", IO_sig_ovf);
        end
    endtask

    task automatic test_stop_pop_push();
        logic [9:0] got;
        int         k;
        frame_q.delete();
        start_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge sig_clk);
            IO_sig_strobe = 1'b1;
            IO_data       = 8'h20 + 8'(i);
        end
        @(negedge sig_clk);
        IO_sig_strobe = 1'b0;
        // The first byte's STOP ends and pops on the 161st edge after its strobe.
        repeat (FRAME_CLKS - 4) @(negedge sig_clk);
        n_checks++;
        if ({IO_sig_full, IO_sig_ovf} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL stoppop_pre full,ovf: got %b expected 10", {IO_sig_full, IO_sig_ovf});
        end
        IO_sig_strobe = 1'b1;
        IO_data       = 8'h25;
        @(negedge sig_clk);
        IO_sig_strobe = 1'b0;
        n_checks++;
        if ({IO_sig_full, IO_sig_ovf} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL stoppop_post full,ovf: got %b expected 10", {IO_sig_full, IO_sig_ovf});
        end
        k = 0;
        while (IO_sig_busy !== 1'b0 && k < 1200) begin
            @(negedge sig_clk);
            k++;
        end
        n_checks++;
        if (frame_q.size() != 6) begin
            n_fail++;
            $display("[TB] FAIL stoppop_frame_count: got %0d expected 6", frame_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                got = frame_q.pop_front();
                n_checks++;
                if (got !== {1'b1, 8'h20 + 8'(i), 1'b0}) begin
                    n_fail++;
                    $display("[TB] FAIL stoppop_frame_%0d: got %b expected %b", i, got,
                             {1'b1, 8'h20 + 8'(i), 1'b0});
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n_starts;
        frame_q.delete();
        start_q.delete();
        @(negedge sig_clk);
        IO_sig_strobe = 1'b1;
        IO_data       = 8'hFF;
        @(negedge sig_clk);
        IO_data       = 8'h11;
        @(negedge sig_clk);
        IO_data       = 8'h22;
        @(negedge sig_clk);
        IO_sig_strobe = 1'b0;
        repeat (60) @(negedge sig_clk);
        n_checks++;
        if (IO_sig_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midrst_busy_before: got %b expected 1", IO_sig_busy);
        end
        n_starts  = start_q.size();
        sig_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({UART_tx, IO_sig_busy, IO_sig_full, IO_sig_ovf} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL midrst_async: got %b expected 1000",
                     {UART_tx, IO_sig_busy, IO_sig_full, IO_sig_ovf});
        end
        repeat (3) @(negedge sig_clk);
        sig_rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge sig_clk);
            n_checks++;
            if ({UART_tx, IO_sig_busy} !== 2'b10) begin
                n_fail++;
                $display("[TB] FAIL midrst_after_%0d tx,busy: got %b expected 10", i,
                         {UART_tx, IO_sig_busy});
            end
        end
        n_checks++;
        if (start_q.size() != n_starts) begin
            n_fail++;
            $display("[TB] FAIL midrst_no_new_frames: got %0d starts expected %0d",
                     start_q.size(), n_starts);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_stop_pop_push();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_module.md
Name: uart_tx_module

Overview:
- Serial transmitter directly downstream of the memory-mapped output port (TARGET_ADDR 8'hFF).
- Consumes each byte the output port latches, plus a one-cycle write strobe issued by the port in the same cycle the byte becomes valid.
- Buffers bytes in a small FIFO and shifts them out as 8N1 UART frames on a single pin.
- Exposes full/busy/overflow status for a future status-register read path.

Parameters:
CLKS_PER_BIT, 16, sig_clk cycles per serial bit; must be >= 2.
FIFO_DEPTH_LOG2, 2, log2 of FIFO entries (default 4 entries).

Ports:
sig_clk  input  1  system clock; all state changes on its rising edge.
sig_rst_n  input  1  asynchronous, active-low reset.
IO_data  input  8  byte from the output port.
IO_sig_strobe  input  1  one-cycle write pulse; IO_data is valid in the same cycle.
IO_sig_ovf_clr  input  1  clears the sticky overflow flag.
UART_tx  output  1  serial line; idle high.
IO_sig_full  output  1  FIFO holds FIFO_DEPTH entries.
IO_sig_busy  output  1  frame in progress or FIFO non-empty.
IO_sig_ovf  output  1  sticky: a strobe arrived while the write could not be accepted.

Behaviour:
- Reset (asynchronous assert, synchronous release): UART_tx=1, IO_sig_full=0, IO_sig_busy=0, IO_sig_ovf=0. FIFO pointers, bit counter and baud counter are all 0; FSM is IDLE.
- Reset mid-frame aborts the frame: UART_tx returns to 1 immediately and FIFO contents are discarded.
- FIFO:
  - Circular buffer with read and write pointers of FIFO_DEPTH_LOG2+1 bits; wrap-around uses the extra MSB to tell full from empty.
  - A push happens on a strobe when not full, or when full and a pop occurs in the same cycle.
  - A strobe that is not accepted drops the byte and sets IO_sig_ovf.
  - Simultaneous push and pop on an empty FIFO is illegal: a pop requires non-empty, so the push lands and the pop waits one cycle.
- Overflow flag:
  - IO_sig_ovf stays set until IO_sig_ovf_clr.
  - If clear and a new overflow occur in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty, pop the head into an 8-bit shift register, go to START, load baud counter to 0.
  - START: UART_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter 0.
  - DATA: UART_tx=shift[0], LSB first. Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After bit 7 completes, go to STOP.
  - STOP: UART_tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Latency: a strobe sampled at edge E into an empty, idle block causes UART_tx to fall after edge E+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- UART_tx is driven from a register, so it is glitch-free.
- IO_sig_busy = (state != IDLE) | ~empty.
- IO_sig_full is combinational from the pointers.
- The baud counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1, and wraps to 0 at each bit boundary.

Decomposition:
- Shared package smolproc_io_pkg holds:
  - tx_state_t, an enum of IDLE/START/DATA/STOP;
  - constant UART_FRAME_BITS=10;
  - constant IO_UART_ADDR=8'hFF.
- The FIFO is a natural sub-module, io_fifo, parameterised by width and depth log2. It has push/pop/full/empty ports and the same sig_clk/sig_rst_n.
- The FSM, baud counter and shift register stay in uart_tx_module.

Test Plan:
- Reset, then no strobes for 100 cycles -> UART_tx=1, busy=0, full=0, ovf=0 throughout.
- Single strobe with IO_data=8'hA5 -> start bit falls one cycle after the strobe edge. Sampling mid-bit yields 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). busy deasserts after 160 cycles.
- Strobes with 8'h01, 8'h02, 8'h03 on consecutive cycles -> three frames back-to-back, with no high gap beyond each stop bit. Total 480 cycles, no overflow.
- Six strobes on consecutive cycles (8'h10..8'h15) -> the first is popped immediately and the next four fill the FIFO, full=1. The sixth is dropped and ovf=1. Bytes 10..14 are transmitted; ovf stays 1 until IO_sig_ovf_clr, then reads 0.
- Strobe while full in the exact cycle STOP ends and pops -> byte accepted, ovf stays 0, frame order preserved.
- Assert sig_rst_n=0 mid-DATA of 8'hFF with two bytes queued -> UART_tx=1 immediately, busy=0. After release, no further frames are sent.
